// File: rtl/nand_flash_responder.sv
// nand_flash_responder: clock-sampled NAND flash target with page array, page register and ready/busy
module nand_flash_responder #(
  parameter int PAGE_BYTES = 512,
  parameter int NUM_PAGES  = 512,
  parameter int BUSY_EXTRA = 16,
  parameter int RST_BUSY   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  input  logic       cle,
  input  logic       ale,
  input  logic       wen,
  input  logic       ren,
  output logic       rb
);
  localparam int LW = $clog2(PAGE_BYTES);
  localparam int CW = LW + 1;
  localparam int AW = $clog2(NUM_PAGES * PAGE_BYTES);
  localparam int NW = $clog2(PAGE_BYTES + BUSY_EXTRA + RST_BUSY + 1);
  localparam logic [CW-1:0] COL_END = CW'(PAGE_BYTES);
  localparam logic [NW-1:0] XFER_END = NW'(PAGE_BYTES);
  localparam logic [NW-1:0] OP_LAST = NW'(PAGE_BYTES + BUSY_EXTRA - 1);
  localparam logic [NW-1:0] RST_LAST = NW'(RST_BUSY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_RD_BUSY, S_RD_OUT, S_PRG_IN, S_PRG_BUSY, S_RST_BUSY
  } state_t;

  state_t state_q, state_d;
  logic wen_q, ren_q;
  logic [CW-1:0] col_q, col_d;
  logic half_q, half_d;
  logic prog_q, prog_d;
  logic [15:0] row_q, row_d;
  logic [1:0] addr_cnt_q, addr_cnt_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [7:0] io_out_q, io_out_d;
  logic io_oe_q, io_oe_d;
  logic rb_q, rb_d;
  logic [7:0] mem [NUM_PAGES*PAGE_BYTES] = '{default: 8'hFF};
  logic [PAGE_BYTES*8-1:0] page_reg;
  logic [AW-1:0] mem_addr;
  logic mem_we, pg_we, pg_fill;
  logic [LW-1:0] pg_addr;
  logic [7:0] pg_wdata;
  logic wen_rise, ren_rise, is_cmd, is_addr, is_data, busy, op_last;

  assign wen_rise = !wen_q && wen;
  assign ren_rise = !ren_q && ren && !wen_rise;
  assign is_cmd   = wen_rise && cle && !ale;
  assign is_addr  = wen_rise && ale && !cle;
  assign is_data  = wen_rise && !ale && !cle;
  assign busy     = state_q inside {S_RD_BUSY, S_PRG_BUSY, S_RST_BUSY};
  assign op_last  = cnt_q == (state_q == S_RST_BUSY ? RST_LAST : OP_LAST);
  assign mem_addr = AW'({row_q, cnt_q[LW-1:0]});
  assign io_out   = io_out_q;
  assign io_oe    = io_oe_q;
  assign rb       = rb_q;

  // command/address/data decode, busy sequencing and page-register/array transfer control
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    half_d = half_q;
    prog_d = prog_q;
    row_d = row_q;
    addr_cnt_d = addr_cnt_q;
    cnt_d = cnt_q;
    mem_we = 1'b0;
    pg_we = 1'b0;
    pg_fill = 1'b0;
    pg_addr = col_q[LW-1:0];
    pg_wdata = io_in;
    if (is_cmd && io_in == 8'hFF) begin
      state_d = S_RST_BUSY;
      cnt_d = '0;
      half_d = 1'b0;
      col_d = '0;
      addr_cnt_d = '0;
    end else if (busy) begin
      cnt_d = cnt_q + NW'(1);
      if (state_q == S_RD_BUSY) begin
        pg_we = cnt_q < XFER_END;
        pg_addr = cnt_q[LW-1:0];
        pg_wdata = mem[mem_addr];
      end
      mem_we = state_q == S_PRG_BUSY && cnt_q < XFER_END;
      if (op_last) state_d = state_q == S_RD_BUSY ? S_RD_OUT : S_IDLE;
    end else if (is_cmd) begin
      if (io_in == 8'h00 || io_in == 8'h01 || io_in == 8'h80) begin
        state_d = S_ADDR;
        addr_cnt_d = '0;
        half_d = io_in == 8'h80 ? half_q : io_in[0];
        prog_d = io_in[7];
      end else if (io_in == 8'h10 && state_q == S_PRG_IN) begin
        state_d = S_PRG_BUSY;
        cnt_d = '0;
      end
    end else if (is_addr && state_q == S_ADDR) begin
      addr_cnt_d = addr_cnt_q + 2'd1;
      if (addr_cnt_q == 2'd0) col_d = CW'(io_in) + (half_q ? CW'(256) : '0);
      if (addr_cnt_q == 2'd1) row_d = {row_q[15:8], io_in};
      if (addr_cnt_q == 2'd2) begin
        row_d = 16'(17'({io_in, row_q[7:0]}) % 17'(NUM_PAGES));
        state_d = prog_q ? S_PRG_IN : S_RD_BUSY;
        cnt_d = '0;
        pg_fill = prog_q;
      end
    end else if (is_data && state_q == S_PRG_IN && col_q < COL_END) begin
      pg_we = 1'b1;
      col_d = col_q + CW'(1);
    end else if (ren_rise && state_q == S_RD_OUT && col_q < COL_END) begin
      col_d = col_q + CW'(1);
    end
  end

  // registered pin outputs derived from the next state
  always_comb begin
    rb_d = !(state_d inside {S_RD_BUSY, S_PRG_BUSY, S_RST_BUSY});
    io_oe_d = state_d == S_RD_OUT && !ren;
    io_out_d = (state_d == S_RD_OUT && col_d < COL_END) ? page_reg[{col_d[LW-1:0], 3'b000} +: 8] : 8'hFF;
  end

  // control state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wen_q <= 1'b1;
      ren_q <= 1'b1;
      col_q <= '0;
      half_q <= 1'b0;
      prog_q <= 1'b0;
      row_q <= '0;
      addr_cnt_q <= '0;
      cnt_q <= '0;
      io_out_q <= 8'hFF;
      io_oe_q <= 1'b0;
      rb_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wen_q <= wen;
      ren_q <= ren;
      col_q <= col_d;
      half_q <= half_d;
      prog_q <= prog_d;
      row_q <= row_d;
      addr_cnt_q <= addr_cnt_d;
      cnt_q <= cnt_d;
      io_out_q <= io_out_d;
      io_oe_q <= io_oe_d;
      rb_q <= rb_d;
    end
  end

  // page register: whole-page preset on program entry, otherwise one byte per cycle
  always_ff @(posedge clk) begin
    if (pg_fill) page_reg <= '1;
    else if (pg_we) page_reg[{pg_addr, 3'b000} +: 8] <= pg_wdata;
  end

  // array write-back from the page register during program busy
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= page_reg[{cnt_q[LW-1:0], 3'b000} +: 8];
  end
endmodule

// File: tb/tb_nand_flash_responder.sv
// tb_nand_flash_responder: scoreboard bench driving the NAND pin protocol against a byte-array model
module tb_nand_flash_responder;
  localparam int PB = 512;
  localparam int NP = 512;
  localparam int BE = 16;
  localparam int RB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cle = 1'b0;
  logic ale = 1'b0;
  logic wen = 1'b1;
  logic ren = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic io_oe;
  logic rb;
  int errors = 0;
  int checks = 0;
  logic [7:0] model [NP*PB];
  logic [7:0] exp_q[$];

  nand_flash_responder #(.PAGE_BYTES(PB), .NUM_PAGES(NP), .BUSY_EXTRA(BE), .RST_BUSY(RB)) dut (
    .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
    .cle(cle), .ale(ale), .wen(wen), .ren(ren), .rb(rb)
  );

  always #5 clk = ~clk;

  task automatic wr_byte(input logic c, input logic a, input logic [7:0] d);
    @(negedge clk);
    cle = c;
    ale = a;
    io_in = d;
    wen = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    @(negedge clk);
    cle = 1'b0;
    ale = 1'b0;
  endtask

  task automatic send_addr(input int col, input int row);
    logic [15:0] r;
    r = 16'(row);
    wr_byte(1'b0, 1'b1, 8'(col));
    wr_byte(1'b0, 1'b1, r[7:0]);
    wr_byte(1'b0, 1'b1, r[15:8]);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (rb === 1'b0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_byte(output logic [7:0] v, output logic oe);
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    v = io_out;
    oe = io_oe;
    ren = 1'b1;
    @(negedge clk);
  endtask

  task automatic program_page(input int row, input bit xor_pat);
    int n;
    int base;
    logic [7:0] b;
    base = (row % NP) * PB;
    wr_byte(1'b1, 1'b0, 8'h80);
    send_addr(0, row);
    for (int i = 0; i < PB; i++) begin
      b = xor_pat ? (8'(i) ^ 8'h5A) : 8'(i * 3 + 7);
      model[base + i] = b;
      wr_byte(1'b0, 1'b0, b);
    end
    wr_byte(1'b1, 1'b0, 8'h10);
    busy_len(n);
    checks++;
    if (n !== PB + BE) begin
      errors++;
      $display("FAIL prog_busy row %0d: got %0d cycles, expected %0d", row, n, PB + BE);
    end
  endtask

  task automatic read_page(input int row, input bit half, input int col0, input int n);
    int c;
    int base;
    int bl;
    logic [7:0] v;
    logic [7:0] e;
    logic oe;
    base = (row % NP) * PB;
    for (int i = 0; i < n; i++) begin
      c = col0 + (half ? 256 : 0) + i;
      exp_q.push_back(c < PB ? model[base + c] : 8'hFF);
    end
    wr_byte(1'b1, 1'b0, half ? 8'h01 : 8'h00);
    send_addr(col0, row);
    busy_len(bl);
    checks++;
    if (bl !== PB + BE) begin
      errors++;
      $display("FAIL read_busy row %0d: got %0d cycles, expected %0d", row, bl, PB + BE);
    end
    for (int i = 0; i < n; i++) begin
      rd_byte(v, oe);
      e = exp_q.pop_front();
      checks++;
      if (v !== e) begin
        errors++;
        $display("FAIL read_data row %0d byte %0d: got %02h, expected %02h", row, i, v, e);
      end
      checks++;
      if (oe !== 1'b1) begin
        errors++;
        $display("FAIL read_oe row %0d byte %0d: got %b, expected 1", row, i, oe);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic oe;
    #3 rst = 1'b1;
    #15 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rb !== 1'b1) begin errors++; $display("FAIL reset_rb: got %b, expected 1", rb); end
    checks++;
    if (io_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, expected 0", io_oe); end
    checks++;
    if (io_out !== 8'hFF) begin errors++; $display("FAIL reset_io_out: got %02h, expected ff", io_out); end
    rd_byte(v, oe);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL idle_ren_oe: got %b, expected 0", oe); end
    checks++;
    if (v !== 8'hFF) begin errors++; $display("FAIL idle_ren_out: got %02h, expected ff", v); end
  endtask

  task automatic test_read();
    program_page(5, 1'b0);
    read_page(5, 1'b0, 0, PB + 1);
    read_page(5 + NP, 1'b0, 0, 4);
  endtask

  task automatic test_program();
    program_page(298, 1'b1);
    read_page(298, 1'b0, 0, PB);
    read_page(297, 1'b0, 0, PB);
  endtask

  task automatic test_partial();
    int n;
    logic [7:0] pat [4];
    pat[0] = 8'hAA;
    pat[1] = 8'hBB;
    pat[2] = 8'hCC;
    pat[3] = 8'hDD;
    wr_byte(1'b1, 1'b0, 8'h01);
    wr_byte(1'b1, 1'b0, 8'h80);
    wr_byte(1'b0, 1'b1, 8'h10);
    wr_byte(1'b0, 1'b1, 8'h03);
    wr_byte(1'b0, 1'b0, 8'h77);
    wr_byte(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 4; k++) begin
      model[3 * PB + 272 + k] = pat[k];
      wr_byte(1'b0, 1'b0, pat[k]);
    end
    wr_byte(1'b1, 1'b1, 8'h11);
    wr_byte(1'b1, 1'b0, 8'h10);
    busy_len(n);
    checks++;
    if (n !== PB + BE) begin errors++; $display("FAIL partial_busy: got %0d cycles, expected %0d", n, PB + BE); end
    read_page(3, 1'b0, 0, PB);
    read_page(3, 1'b1, 8'h10, 5);
  endtask

  task automatic test_reset_cmd();
    int n;
    wr_byte(1'b1, 1'b0, 8'h00);
    send_addr(0, 0);
    repeat (100) @(negedge clk);
    checks++;
    if (rb !== 1'b0) begin errors++; $display("FAIL mid_read_busy: got rb=%b, expected 0", rb); end
    wr_byte(1'b1, 1'b0, 8'hFF);
    busy_len(n);
    checks++;
    if (n !== RB) begin errors++; $display("FAIL ff_busy: got %0d cycles, expected %0d", n, RB); end
    wr_byte(1'b1, 1'b0, 8'h90);
    send_addr(0, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (rb !== 1'b1) begin errors++; $display("FAIL cmd90_ignored: got rb=%b, expected 1", rb); end
    read_page(0, 1'b0, 0, 8);
  endtask

  task automatic test_collision();
    int n;
    logic [7:0] v;
    logic oe;
    logic [7:0] e;
    read_page(298, 1'b0, 0, 2);
    e = model[298 * PB + 2];
    @(negedge clk);
    cle = 1'b1;
    io_in = 8'h90;
    wen = 1'b0;
    ren = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    ren = 1'b1;
    @(negedge clk);
    cle = 1'b0;
    rd_byte(v, oe);
    checks++;
    if (v !== e) begin errors++; $display("FAIL collision_col: got %02h, expected %02h", v, e); end
    checks++;
    if (oe !== 1'b1) begin errors++; $display("FAIL collision_oe: got %b, expected 1", oe); end
    @(negedge clk);
    cle = 1'b1;
    io_in = 8'hFF;
    wen = 1'b0;
    ren = 1'b0;
    @(negedge clk);
    wen = 1'b1;
    ren = 1'b1;
    @(negedge clk);
    cle = 1'b0;
    busy_len(n);
    checks++;
    if (n !== RB) begin errors++; $display("FAIL collision_ff_busy: got %0d cycles, expected %0d", n, RB); end
    checks++;
    if (io_oe !== 1'b0 || io_out !== 8'hFF) begin
      errors++;
      $display("FAIL collision_after: got oe=%b out=%02h, expected oe=0 out=ff", io_oe, io_out);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation still running at 3 ms, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NP * PB; i++) model[i] = 8'hFF;
    test_reset();
    test_read();
    test_program();
    test_partial();
    test_reset_cmd();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
